instr_encoder_writer: RTL and testbench
=======================================

INSTR_ENCODER_WRITER -- requirements
Module: instr_encoder_writer

Interface
REQ-001 SHALL have one clock and one reset: clk, rst; reset is asynchronous and active-high.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  rising-edge clock
- rst  in  1  async active-high reset
- start  in  1  begin session, one-cycle pulse
- base_addr  in  32  first write byte address, sampled on accepted start
- in_valid  in  1  instruction fields valid
- in_ready  out  1  block can accept fields
- in_last  in  1  marks final instruction of session
- in_cond  in  4  condition field
- in_mode  in  2  00 data-proc, 01 memory, 10 branch, 11 illegal
- in_opcode  in  4  data-proc opcode
- in_s  in  1  S flag for data-proc; L flag for memory (1 = load)
- in_i  in  1  immediate flag for data-proc
- in_rn  in  4  first operand register
- in_rd  in  4  destination register
- in_imm  in  24  [11:0] shifter operand / offset; [23:0] branch offset
- mem_w_en  out  1  write request to instruction memory
- mem_addr  out  32  write byte address
- mem_wdata  out  32  encoded instruction word
- mem_ready  in  1  memory accepts the write this cycle
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse at session end
- err_cnt  out  8  illegal instructions dropped this session

Function
REQ-003 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-004 IDLE: start=1 -> RUN; load mem_addr from base_addr; clear err_cnt; in_ready=0 in IDLE.
REQ-005 start SHALL be ignored outside IDLE.
REQ-006 Input handshake: transfer occurs when in_valid && in_ready; in_ready = (state==RUN) && (fifo count < 4).
REQ-007 In RUN, a transfer with in_last=1 SHALL move to DRAIN after that cycle; in_ready=0 in DRAIN.
REQ-008 DRAIN -> DONE when FIFO is empty and no write is pending; DONE asserts done for exactly one cycle, then -> IDLE.
REQ-009 Encoding, mode 00: {cond, 2'b00, i, opcode, s, rn, rd, imm[11:0]}.
REQ-010 Encoding, mode 01: {cond, 2'b01, 1'b0, 4'b1100, s, rn, rd, imm[11:0]}.
REQ-011 Encoding, mode 10: {cond, 3'b101, 1'b0, imm[23:0]}; opcode, s, i, rn, rd ignored.
REQ-012 mode 11: transfer completes but word is not enqueued; err_cnt increments, saturating at 255; in_last on such a transfer still moves to DRAIN.
REQ-013 Encoded words SHALL enter a 4-entry FIFO in transfer order; encode is combinational at the transfer, write at the registered FIFO output.
REQ-014 mem_w_en = FIFO not empty; mem_wdata = FIFO head; mem_addr = current address register.
REQ-015 A write completes when mem_w_en && mem_ready: pop head, mem_addr += 4 (wraps modulo 2^32).
REQ-016 mem_wdata and mem_addr SHALL stay stable while mem_w_en=1 and mem_ready=0.
REQ-017 Latency: a word transferred in cycle N SHALL be visible on mem_w_en no earlier than cycle N+1; no bypass around the FIFO.
REQ-018 Simultaneous push and pop: count unchanged. Push is blocked when full even if a pop occurs that cycle.
REQ-019 busy = (state != IDLE).

Reset
REQ-020 rst SHALL, at any time including mid-session, force: state IDLE, FIFO empty, mem_addr=0, err_cnt=0, in_ready=0, mem_w_en=0, done=0, busy=0.
REQ-021 Words already queued at reset SHALL be discarded and not written.

Verification
REQ-022 Data-proc encode: start, base 0x100; send cond E, mode 00, i=1, opcode 0100, s=0, rn=1, rd=2, imm 0x005, last=1; mem_ready=1 -> one write 0xE2812005 @0x100, then done pulse, err_cnt=0.
REQ-023 Memory and branch encode: send LDR (cond E, mode 01, s=1, rn=0, rd=3, imm 0x004), then branch (cond E, mode 10, imm 0xFFFFFE, last) -> writes 0xE5903004 @base, then 0xEAFFFFFE @base+4.
REQ-024 Backpressure: mem_ready=0 while 6 items are offered -> exactly 4 transfers, in_ready=0 afterward, outputs stable; then raise mem_ready -> all 6 written in order, addresses +4 each.
REQ-025 Illegal: send 3 instructions with the middle one mode 11 -> 2 writes at consecutive addresses, err_cnt=1 at done.
REQ-026 Reset mid-session: assert rst with 3 queued words -> all outputs at reset values at once; no further writes; a new start runs normally.

Source files
------------

// File: rtl/instr_encoder_writer.sv
// instr_encoder_writer: encodes instruction fields into 32-bit words and
// writes them through a 4-entry FIFO to consecutive instruction-memory words.
module instr_encoder_writer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [3:0]  in_cond,
  input  logic [1:0]  in_mode,
  input  logic [3:0]  in_opcode,
  input  logic        in_s,
  input  logic        in_i,
  input  logic [3:0]  in_rn,
  input  logic [3:0]  in_rd,
  input  logic [23:0] in_imm,
  output logic        mem_w_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic [7:0]  err_cnt
);

  localparam int DEPTH = 4;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic [DEPTH-1:0][31:0] fifo_mem;
  logic [1:0]             wr_ptr, rd_ptr;
  logic [2:0]             count;

  logic        xfer, illegal, push, pop, start_acc;
  logic [31:0] enc_word;

  assign xfer      = in_valid && in_ready;
  assign illegal   = (in_mode == 2'b11);
  // Illegal transfers complete the handshake but never reach the FIFO.
  assign push      = xfer && !illegal;
  assign pop       = mem_w_en && mem_ready;
  assign start_acc = (state == IDLE) && start;

  assign mem_w_en  = (count != 3'd0);
  assign mem_wdata = fifo_mem[rd_ptr];

  // Combinational encode of the fields presented at the transfer.
  always_comb begin
    enc_word = 32'h0;
    case (in_mode)
      2'b00:   enc_word = {in_cond, 2'b00, in_i, in_opcode, in_s, in_rn, in_rd, in_imm[11:0]};
      2'b01:   enc_word = {in_cond, 2'b01, 1'b0, 4'b1100, in_s, in_rn, in_rd, in_imm[11:0]};
      2'b10:   enc_word = {in_cond, 3'b101, 1'b0, in_imm};
      default: enc_word = 32'h0;
    endcase
  end

  // Session state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake/status outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        // A full FIFO blocks input even if the head is leaving this cycle.
        in_ready = (count < 3'(DEPTH));
        if (xfer && in_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (count == 3'd0) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write address and per-session illegal-instruction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr <= 32'h0;
      err_cnt  <= 8'h0;
    end else begin
      if (start_acc)  mem_addr <= base_addr;
      else if (pop)   mem_addr <= mem_addr + 32'd4;
      if (start_acc)                          err_cnt <= 8'h0;
      else if (xfer && illegal && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  // FIFO pointers and occupancy; reset discards anything queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are meaningless while count is zero.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= enc_word;
  end

endmodule

// File: tb/tb_instr_encoder_writer.sv
// Scoreboard bench for instr_encoder_writer: expected {addr,word} pairs are
// queued on each accepted transfer and checked when the DUT writes memory.
module tb_instr_encoder_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [3:0]  in_cond;
  logic [1:0]  in_mode;
  logic [3:0]  in_opcode;
  logic        in_s;
  logic        in_i;
  logic [3:0]  in_rn;
  logic [3:0]  in_rd;
  logic [23:0] in_imm;
  logic        mem_w_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        busy;
  logic        done;
  logic [7:0]  err_cnt;

  int total = 0;
  int bad   = 0;

  logic [63:0] sb[$];
  logic [31:0] exp_addr;

  instr_encoder_writer dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_cond(in_cond), .in_mode(in_mode), .in_opcode(in_opcode),
    .in_s(in_s), .in_i(in_i), .in_rn(in_rn), .in_rd(in_rd), .in_imm(in_imm),
    .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .busy(busy), .done(done), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_word(input logic [3:0] cond, input logic [1:0] mode,
      input logic [3:0] opc, input logic s, input logic i, input logic [3:0] rn,
      input logic [3:0] rd, input logic [23:0] imm);
    logic [31:0] w;
    w = 32'h0;
    if (mode == 2'b00)      w = {cond, 2'b00, i, opc, s, rn, rd, imm[11:0]};
    else if (mode == 2'b01) w = {cond, 2'b01, 1'b0, 4'b1100, s, rn, rd, imm[11:0]};
    else if (mode == 2'b10) w = {cond, 3'b101, 1'b0, imm};
    return w;
  endfunction

  // Write monitor: every completed write must match the scoreboard head.
  always @(negedge clk) begin
    if (mem_w_en && mem_ready) begin
      logic [63:0] e;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write addr=%h data=%h (none expected)", mem_addr, mem_wdata);
      end else begin
        e = sb.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          bad++;
          $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                   mem_addr, mem_wdata, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic do_start(input logic [31:0] base);
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; exp_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic set_fields(input logic [3:0] cond, input logic [1:0] mode, input logic [3:0] opc,
      input logic s, input logic i, input logic [3:0] rn, input logic [3:0] rd,
      input logic [23:0] imm, input logic last);
    in_cond = cond; in_mode = mode; in_opcode = opc; in_s = s; in_i = i;
    in_rn = rn; in_rd = rd; in_imm = imm; in_last = last; in_valid = 1'b1;
  endtask

  // Offer one instruction; returns at posedge+1 after the transfer.
  task automatic send(input logic [3:0] cond, input logic [1:0] mode, input logic [3:0] opc,
      input logic s, input logic i, input logic [3:0] rn, input logic [3:0] rd,
      input logic [23:0] imm, input logic last, input bit chk_lat);
    bit ok = 0;
    set_fields(cond, mode, opc, s, i, rn, rd, imm, last);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (in_ready) begin
        if (chk_lat) begin
          total++;
          if (mem_w_en !== 1'b0) begin
            bad++; $display("FAIL latency mem_w_en=%b want 0 before transfer", mem_w_en);
          end
        end
        if (mode != 2'b11) begin
          sb.push_back({exp_addr, exp_word(cond, mode, opc, s, i, rn, rd, imm)});
          exp_addr = exp_addr + 32'd4;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        ok = 1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++; $display("FAIL send_timeout in_ready=%b want 1", in_ready);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input logic [7:0] exp_err);
    bit seen = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL done_timeout done=%b want 1", done);
    end else begin
      total++;
      if (err_cnt !== exp_err) begin
        bad++; $display("FAIL err_cnt got=%0d want=%0d", err_cnt, exp_err);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL done_pulse done=%b busy=%b want 0 0", done, busy);
      end
    end
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL sb_empty pending=%0d want 0", sb.size());
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if ({in_ready, mem_w_en, done, busy} !== 4'b0 || mem_addr !== 32'h0 || err_cnt !== 8'h0) begin
      bad++;
      $display("FAIL reset rdy=%b wen=%b done=%b busy=%b addr=%h err=%0d want all 0",
               in_ready, mem_w_en, done, busy, mem_addr, err_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_dataproc;
    mem_ready = 1'b1;
    do_start(32'h100);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy got=%b want 1", busy); end
    send(4'hE, 2'b00, 4'b0100, 1'b0, 1'b1, 4'd1, 4'd2, 24'h005, 1'b1, 1'b1);
    total++;
    if (sb.size() != 1 || sb[0] !== {32'h100, 32'hE2812005}) begin
      bad++; $display("FAIL dp_expect got=%h want %h", sb[0], {32'h100, 32'hE2812005});
    end
    wait_done(8'd0);
  endtask

  // Base near the top of the address space exercises address wrap.
  task automatic test_mem_branch;
    mem_ready = 1'b1;
    do_start(32'hFFFF_FFFC);
    send(4'hE, 2'b01, 4'b0000, 1'b1, 1'b0, 4'd0, 4'd3, 24'h000004, 1'b0, 1'b0);
    send(4'hE, 2'b10, 4'b1111, 1'b1, 1'b1, 4'd7, 4'd7, 24'hFFFFFE, 1'b1, 1'b0);
    wait_done(8'd0);
  endtask

  task automatic test_backpressure;
    logic [31:0] a0, d0;
    mem_ready = 1'b0;
    do_start(32'h2000);
    for (int k = 0; k < 4; k++)
      send(4'hA, 2'b00, 4'(k), 1'b1, 1'b0, 4'(k), 4'(k + 8), 24'(12'h100 + k), 1'b0, 1'b0);
    set_fields(4'hA, 2'b00, 4'd4, 1'b1, 1'b0, 4'd4, 4'd12, 24'h104, 1'b0);
    @(negedge clk);
    a0 = mem_addr; d0 = mem_wdata;
    total++;
    if (in_ready !== 1'b0 || mem_w_en !== 1'b1 || {a0, d0} !== sb[0]) begin
      bad++; $display("FAIL bp_full rdy=%b wen=%b head=%h want rdy=0 wen=1 head=%h",
                      in_ready, mem_w_en, {a0, d0}, sb[0]);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0 || mem_addr !== a0 || mem_wdata !== d0) begin
        bad++; $display("FAIL bp_stable rdy=%b addr=%h data=%h want 0 %h %h",
                        in_ready, mem_addr, mem_wdata, a0, d0);
      end
    end
    @(posedge clk); #1;
    mem_ready = 1'b1;
    send(4'hA, 2'b00, 4'd4, 1'b1, 1'b0, 4'd4, 4'd12, 24'h104, 1'b0, 1'b0);
    send(4'hA, 2'b00, 4'd5, 1'b1, 1'b0, 4'd5, 4'd13, 24'h105, 1'b1, 1'b0);
    wait_done(8'd0);
  endtask

  // Middle instruction illegal; a stray start in RUN must be ignored.
  task automatic test_illegal;
    mem_ready = 1'b1;
    do_start(32'h40);
    send(4'h0, 2'b00, 4'b1101, 1'b0, 1'b1, 4'd0, 4'd1, 24'h0FF, 1'b0, 1'b0);
    start = 1'b1; base_addr = 32'hDEAD_0000;
    send(4'h0, 2'b11, 4'b0000, 1'b0, 1'b0, 4'd0, 4'd0, 24'h0, 1'b0, 1'b0);
    start = 1'b0;
    send(4'h1, 2'b01, 4'b0000, 1'b0, 1'b0, 4'd2, 4'd5, 24'h010, 1'b1, 1'b0);
    wait_done(8'd1);
  endtask

  task automatic test_reset_mid;
    mem_ready = 1'b0;
    do_start(32'h300);
    for (int k = 0; k < 3; k++)
      send(4'hE, 2'b00, 4'd1, 1'b0, 1'b1, 4'd1, 4'(k), 24'(k), 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({in_ready, mem_w_en, done, busy} !== 4'b0 || mem_addr !== 32'h0 || err_cnt !== 8'h0) begin
      bad++;
      $display("FAIL reset_mid rdy=%b wen=%b done=%b busy=%b addr=%h err=%0d want all 0",
               in_ready, mem_w_en, done, busy, mem_addr, err_cnt);
    end
    sb.delete();
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    total++;
    if (mem_w_en !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL post_reset wen=%b busy=%b want 0 0", mem_w_en, busy);
    end
    test_dataproc();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = 32'h0; in_valid = 1'b0; in_last = 1'b0;
    in_cond = 4'h0; in_mode = 2'b00; in_opcode = 4'h0; in_s = 1'b0; in_i = 1'b0;
    in_rn = 4'h0; in_rd = 4'h0; in_imm = 24'h0; mem_ready = 1'b0; exp_addr = 32'h0;
    test_reset();
    test_dataproc();
    test_mem_branch();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
